// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-side hazard inputs and control outputs of hazard_ctrl
interface hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] rs1d_i;
    logic [REG_ADDR_W-1:0] rs2d_i;
    logic [REG_ADDR_W-1:0] rs1e_i;
    logic [REG_ADDR_W-1:0] rs2e_i;
    logic [REG_ADDR_W-1:0] rde_i;
    logic [REG_ADDR_W-1:0] rdm_i;
    logic [REG_ADDR_W-1:0] rdw_i;
    logic [1:0]            resultsrce_i;
    logic                  regwritem_i;
    logic                  regwritew_i;
    logic                  pcsrce_i;
    logic                  memreqm_i;
    logic                  memreadym_i;
    logic                  stallf_o;
    logic                  stalld_o;
    logic                  stalle_o;
    logic                  stallm_o;
    logic                  flushd_o;
    logic                  flushe_o;
    logic                  flushw_o;
    logic [1:0]            forwardae_o;
    logic [1:0]            forwardbe_o;
    logic                  mem_timeout_o;
    logic [CNT_W-1:0]      stall_cnt_o;
    logic [CNT_W-1:0]      flush_cnt_o;

    modport master (
        output rs1d_i, rs2d_i, rs1e_i, rs2e_i, rde_i, rdm_i, rdw_i,
        output resultsrce_i, regwritem_i, regwritew_i, pcsrce_i,
        output memreqm_i, memreadym_i,
        input  stallf_o, stalld_o, stalle_o, stallm_o,
        input  flushd_o, flushe_o, flushw_o,
        input  forwardae_o, forwardbe_o,
        input  mem_timeout_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  rs1d_i, rs2d_i, rs1e_i, rs2e_i, rde_i, rdm_i, rdw_i,
        input  resultsrce_i, regwritem_i, regwritew_i, pcsrce_i,
        input  memreqm_i, memreadym_i,
        output stallf_o, stalld_o, stalle_o, stallm_o,
        output flushd_o, flushe_o, flushw_o,
        output forwardae_o, forwardbe_o,
        output mem_timeout_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/forwarding control with memory wait sequencing
module hazard_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int CNT_W        = 16,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic         clk_i,
    input  logic         reset_i,
    hazard_ctrl_if.slave hz
);
    typedef enum logic {RUN, MEM_WAIT} state_e;

    localparam int                    WCNT_W   = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0]     WAIT_MAX = WCNT_W'(WAIT_TIMEOUT);
    localparam logic [REG_ADDR_W-1:0] X0       = '0;

    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wait_q, wait_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic memstall, lwstall, branch_flush;
    logic stallf, stalld, stalle, stallm, flushd, flushe, flushw;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] rdm,
        input logic                  wm,
        input logic [REG_ADDR_W-1:0] rdw,
        input logic                  ww
    );
        if (rs != X0 && rs == rdm && wm)      return 2'b10;
        else if (rs != X0 && rs == rdw && ww) return 2'b01;
        else                                  return 2'b00;
    endfunction

    assign memstall = hz.memreqm_i && !hz.memreadym_i;
    assign lwstall  = (hz.resultsrce_i == 2'b01) && (hz.rde_i != X0) &&
                      ((hz.rde_i == hz.rs1d_i) || (hz.rde_i == hz.rs2d_i));
    assign branch_flush = !memstall && hz.pcsrce_i;

    // A frozen memory access outranks everything; a taken branch discards the load-use victim.
    always_comb begin
        stallf = 1'b0;
        stalld = 1'b0;
        stalle = 1'b0;
        stallm = 1'b0;
        flushd = 1'b0;
        flushe = 1'b0;
        flushw = 1'b0;
        if (memstall) begin
            stallf = 1'b1;
            stalld = 1'b1;
            stalle = 1'b1;
            stallm = 1'b1;
            flushw = 1'b1;
        end else if (hz.pcsrce_i) begin
            flushd = 1'b1;
            flushe = 1'b1;
        end else if (lwstall) begin
            stallf = 1'b1;
            stalld = 1'b1;
            flushe = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        timeout_d   = timeout_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            RUN:      if (memstall) state_d = MEM_WAIT;
            MEM_WAIT: if (hz.memreadym_i) state_d = RUN;
            default:  state_d = RUN;
        endcase
        // Timeout flags on the edge where the wait count reaches its limit.
        if (memstall) begin
            if (wait_q != WAIT_MAX) wait_d = wait_q + WCNT_W'(1);
            if (wait_q >= WAIT_MAX - WCNT_W'(1)) timeout_d = 1'b1;
        end else if (state_q == MEM_WAIT && hz.memreadym_i) begin
            wait_d = '0;
        end
        if (stallf && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (branch_flush && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= RUN;
            wait_q      <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.stallf_o      = stallf;
    assign hz.stalld_o      = stalld;
    assign hz.stalle_o      = stalle;
    assign hz.stallm_o      = stallm;
    assign hz.flushd_o      = flushd;
    assign hz.flushe_o      = flushe;
    assign hz.flushw_o      = flushw;
    assign hz.forwardae_o   = fwd_sel(hz.rs1e_i, hz.rdm_i, hz.regwritem_i, hz.rdw_i, hz.regwritew_i);
    assign hz.forwardbe_o   = fwd_sel(hz.rs2e_i, hz.rdm_i, hz.regwritem_i, hz.rdw_i, hz.regwritew_i);
    assign hz.mem_timeout_o = timeout_q;
    assign hz.stall_cnt_o   = stall_cnt_q;
    assign hz.flush_cnt_o   = flush_cnt_q;
endmodule
